// File: rtl/bist_scan_sequencer_if.sv
// Handshake bundle between the BIST top level (master) and the scan
// sequencer (slave): session request, MISR verdict input, datapath enables.
interface bist_scan_sequencer_if;
  logic bist_start;
  logic misr_match;
  logic mode;
  logic init;
  logic scan_en;
  logic tpg_en;
  logic misr_en;
  logic running;
  logic finish;
  logic bist_end;
  logic pass_nfail;

  modport master (
    output bist_start,
    output misr_match,
    input  mode,
    input  init,
    input  scan_en,
    input  tpg_en,
    input  misr_en,
    input  running,
    input  finish,
    input  bist_end,
    input  pass_nfail
  );

  modport slave (
    input  bist_start,
    input  misr_match,
    output mode,
    output init,
    output scan_en,
    output tpg_en,
    output misr_en,
    output running,
    output finish,
    output bist_end,
    output pass_nfail
  );
endinterface

// File: rtl/bist_scan_sequencer.sv
// BIST scan sequencer: seeds the TPG, runs N_PATTERNS shift/capture
// patterns through a CHAIN_LEN scan chain, unloads into the MISR and
// latches the signature verdict. Outputs are registered and decoded from
// the next state so they line up cycle-for-cycle with the state register.
module bist_scan_sequencer #(
  parameter int CHAIN_LEN  = 8,
  parameter int N_PATTERNS = 100
) (
  input  logic                  clock,
  input  logic                  reset,
  bist_scan_sequencer_if.slave  bus
);

  localparam int SW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(N_PATTERNS + 1);
  localparam logic [SW-1:0] SHIFT_LAST = SW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PAT_LAST   = PW'(N_PATTERNS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_UNLOAD  = 3'd4,
    S_COMPARE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_shift_cnt;
  logic [SW-1:0]   w_shift_cnt_nxt;
  logic [PW-1:0]   r_pat_cnt;
  logic [PW-1:0]   w_pat_cnt_nxt;
  logic [PW-1:0]   w_pat_inc;
  logic            r_pass_nfail;
  logic            w_pass_nfail_nxt;

  logic            r_mode;
  logic            r_init;
  logic            r_scan_en;
  logic            r_tpg_en;
  logic            r_misr_en;
  logic            r_running;
  logic            r_finish;
  logic            r_bist_end;

  logic            w_mode;
  logic            w_init;
  logic            w_scan_en;
  logic            w_tpg_en;
  logic            w_misr_en;
  logic            w_running;
  logic            w_finish;
  logic            w_bist_end;

  assign w_pat_inc = r_pat_cnt + PW'(1);

  // Next-state, counter and verdict update logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_cnt_nxt  = r_shift_cnt;
    w_pat_cnt_nxt    = r_pat_cnt;
    w_pass_nfail_nxt = r_pass_nfail;
    case (r_state)
      S_IDLE: begin
        if (bist_start_s()) begin
          // Verdict is cleared on entry so it already reads 0 during INIT.
          w_state_nxt      = S_INIT;
          w_shift_cnt_nxt  = {SW{1'b0}};
          w_pat_cnt_nxt    = {PW{1'b0}};
          w_pass_nfail_nxt = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_INIT: begin
        w_state_nxt      = S_SHIFT;
        w_shift_cnt_nxt  = {SW{1'b0}};
        w_pat_cnt_nxt    = {PW{1'b0}};
        w_pass_nfail_nxt = 1'b0;
      end
      S_SHIFT: begin
        if (r_shift_cnt == SHIFT_LAST) begin
          w_state_nxt = S_CAPTURE;
        end else begin
          w_shift_cnt_nxt = r_shift_cnt + SW'(1);
        end
      end
      S_CAPTURE: begin
        w_pat_cnt_nxt   = w_pat_inc;
        w_shift_cnt_nxt = {SW{1'b0}};
        if (w_pat_inc == PAT_LAST) begin
          w_state_nxt = S_UNLOAD;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_UNLOAD: begin
        if (r_shift_cnt == SHIFT_LAST) begin
          w_state_nxt = S_COMPARE;
        end else begin
          w_shift_cnt_nxt = r_shift_cnt + SW'(1);
        end
      end
      S_COMPARE: begin
        w_pass_nfail_nxt = bus.misr_match;
        w_state_nxt      = S_DONE;
      end
      S_DONE: begin
        // A new session needs bist_start to drop first.
        if (!bus.bist_start) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Moore output decode of the upcoming state, registered below.
  always_comb begin
    w_mode     = 1'b0;
    w_init     = 1'b0;
    w_scan_en  = 1'b0;
    w_tpg_en   = 1'b0;
    w_misr_en  = 1'b0;
    w_running  = 1'b0;
    w_finish   = 1'b0;
    w_bist_end = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_mode = 1'b0;
      end
      S_INIT: begin
        w_mode    = 1'b1;
        w_init    = 1'b1;
        w_running = 1'b1;
      end
      S_SHIFT: begin
        w_mode    = 1'b1;
        w_scan_en = 1'b1;
        w_tpg_en  = 1'b1;
        w_running = 1'b1;
        // Chain contents are undefined while loading the first pattern.
        w_misr_en = (w_pat_cnt_nxt != {PW{1'b0}});
      end
      S_CAPTURE: begin
        w_mode    = 1'b1;
        w_running = 1'b1;
      end
      S_UNLOAD: begin
        w_mode    = 1'b1;
        w_scan_en = 1'b1;
        w_misr_en = 1'b1;
        w_running = 1'b1;
      end
      S_COMPARE: begin
        w_mode    = 1'b1;
        w_running = 1'b1;
        w_finish  = 1'b1;
      end
      S_DONE: begin
        w_bist_end = 1'b1;
      end
      default: begin
        w_mode = 1'b0;
      end
    endcase
  end

  // State, counters, verdict and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_shift_cnt  <= {SW{1'b0}};
      r_pat_cnt    <= {PW{1'b0}};
      r_pass_nfail <= 1'b0;
      r_mode       <= 1'b0;
      r_init       <= 1'b0;
      r_scan_en    <= 1'b0;
      r_tpg_en     <= 1'b0;
      r_misr_en    <= 1'b0;
      r_running    <= 1'b0;
      r_finish     <= 1'b0;
      r_bist_end   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift_cnt  <= w_shift_cnt_nxt;
      r_pat_cnt    <= w_pat_cnt_nxt;
      r_pass_nfail <= w_pass_nfail_nxt;
      r_mode       <= w_mode;
      r_init       <= w_init;
      r_scan_en    <= w_scan_en;
      r_tpg_en     <= w_tpg_en;
      r_misr_en    <= w_misr_en;
      r_running    <= w_running;
      r_finish     <= w_finish;
      r_bist_end   <= w_bist_end;
    end
  end

  function automatic logic bist_start_s();
    return bus.bist_start;
  endfunction

  assign bus.mode       = r_mode;
  assign bus.init       = r_init;
  assign bus.scan_en    = r_scan_en;
  assign bus.tpg_en     = r_tpg_en;
  assign bus.misr_en    = r_misr_en;
  assign bus.running    = r_running;
  assign bus.finish     = r_finish;
  assign bus.bist_end   = r_bist_end;
  assign bus.pass_nfail = r_pass_nfail;

endmodule

// File: tb/tb_bist_scan_sequencer.sv
// Bench for bist_scan_sequencer: a default-parameter instance (8 x 100)
// and a minimal one (1 x 1). Expected per-cycle output vectors are derived
// arithmetically from the cycle index since INIT, queued when a session is
// launched and popped/compared on each falling edge.
module tb_bist_scan_sequencer;

  localparam int CL_A = 8;
  localparam int NP_A = 100;
  localparam int CL_B = 1;
  localparam int NP_B = 1;

  // Output vector bit positions.
  localparam logic [8:0] V_MODE  = 9'h100;
  localparam logic [8:0] V_INIT  = 9'h080;
  localparam logic [8:0] V_SCAN  = 9'h040;
  localparam logic [8:0] V_TPG   = 9'h020;
  localparam logic [8:0] V_MISR  = 9'h010;
  localparam logic [8:0] V_RUN   = 9'h008;
  localparam logic [8:0] V_FIN   = 9'h004;
  localparam logic [8:0] V_END   = 9'h002;
  localparam logic [8:0] V_PASS  = 9'h001;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [8:0] exp_q[$];

  bist_scan_sequencer_if ifa();
  bist_scan_sequencer_if ifb();

  bist_scan_sequencer #(.CHAIN_LEN(CL_A), .N_PATTERNS(NP_A)) u_dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa)
  );

  bist_scan_sequencer #(.CHAIN_LEN(CL_B), .N_PATTERNS(NP_B)) u_dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] get_outs(input bit sel);
    if (sel)
      return {ifb.mode, ifb.init, ifb.scan_en, ifb.tpg_en, ifb.misr_en,
              ifb.running, ifb.finish, ifb.bist_end, ifb.pass_nfail};
    else
      return {ifa.mode, ifa.init, ifa.scan_en, ifa.tpg_en, ifa.misr_en,
              ifa.running, ifa.finish, ifa.bist_end, ifa.pass_nfail};
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) ifb.bist_start = v;
    else     ifa.bist_start = v;
  endtask

  task automatic set_match(input bit sel, input logic v);
    if (sel) ifb.misr_match = v;
    else     ifa.misr_match = v;
  endtask

  // Expected outputs in cycle k of a session (k = 1 is INIT).
  function automatic logic [8:0] exp_vec(input int k, input int cl, input int np, input bit verdict);
    int L;
    int sh_end;
    int j;
    logic [8:0] v;
    L      = 2 + np * (cl + 1) + cl;
    sh_end = 1 + np * (cl + 1);
    v      = 9'h000;
    if (k == 1) begin
      v = V_MODE | V_INIT | V_RUN;
    end else if (k <= sh_end) begin
      j = k - 2;
      if ((j % (cl + 1)) < cl)
        v = V_MODE | V_SCAN | V_TPG | V_RUN | (((j / (cl + 1)) != 0) ? V_MISR : 9'h000);
      else
        v = V_MODE | V_RUN;
    end else if (k < L) begin
      v = V_MODE | V_SCAN | V_MISR | V_RUN;
    end else if (k == L) begin
      v = V_MODE | V_RUN | V_FIN;
    end else begin
      v = V_END | (verdict ? V_PASS : 9'h000);
    end
    return v;
  endfunction

  // Launch a session from IDLE (caller sits just after a falling edge).
  task automatic run_session(input bit sel, input bit verdict, input bit glitch, input bit abort);
    int cl;
    int np;
    int L;
    int sh_end;
    int k;
    logic [8:0] e;
    cl     = sel ? CL_B : CL_A;
    np     = sel ? NP_B : NP_A;
    L      = 2 + np * (cl + 1) + cl;
    sh_end = 1 + np * (cl + 1);
    exp_q.delete();
    for (int i = 1; i <= L + 1; i++) exp_q.push_back(exp_vec(i, cl, np, verdict));
    set_start(sel, 1'b1);
    set_match(sel, 1'b1);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      k++;
      e = exp_q.pop_front();
      check_val($sformatf("dut%0d_k%0d", sel, k), {23'd0, get_outs(sel)}, {23'd0, e});
      set_match(sel, (k == L) ? verdict : 1'b1);
      if (glitch && k >= 2 && k < sh_end)
        set_start(sel, (((k / 2) % 2) == 0) ? 1'b0 : 1'b1);
      else
        set_start(sel, 1'b1);
      if (abort && k == 2 + 39 * (cl + 1) + 3) begin
        #2 reset = 1'b0;
        #1 check_val("abort_async", {23'd0, get_outs(sel)}, 32'd0);
        exp_q.delete();
      end
    end
  endtask

  // Hold in DONE, then drop the request and observe IDLE with held verdict.
  task automatic end_session(input bit sel, input bit verdict, input int hold);
    logic [8:0] e;
    for (int i = 0; i < hold; i++) begin
      exp_q.push_back(V_END | (verdict ? V_PASS : 9'h000));
      @(negedge clock);
      e = exp_q.pop_front();
      check_val($sformatf("dut%0d_hold%0d", sel, i), {23'd0, get_outs(sel)}, {23'd0, e});
    end
    set_start(sel, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(verdict ? V_PASS : 9'h000);
      @(negedge clock);
      e = exp_q.pop_front();
      check_val($sformatf("dut%0d_idle%0d", sel, i), {23'd0, get_outs(sel)}, {23'd0, e});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    set_start(1'b0, 1'b0);
    set_start(1'b1, 1'b0);
    set_match(1'b0, 1'b1);
    set_match(1'b1, 1'b1);

    // Reset state of both instances.
    @(negedge clock);
    check_val("reset_a", {23'd0, get_outs(1'b0)}, 32'd0);
    check_val("reset_b", {23'd0, get_outs(1'b1)}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Nominal pass, then 50-cycle hold in DONE and restart handshake.
    run_session(1'b0, 1'b1, 1'b0, 1'b0);
    end_session(1'b0, 1'b1, 50);

    // Fail verdict (pass_nfail must clear at INIT after the previous pass).
    run_session(1'b0, 1'b0, 1'b0, 1'b0);
    end_session(1'b0, 1'b0, 3);

    // Start request glitching during SHIFT/CAPTURE.
    run_session(1'b0, 1'b1, 1'b1, 1'b0);
    end_session(1'b0, 1'b1, 2);

    // Mid-session asynchronous abort, then a full re-run.
    run_session(1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clock);
    check_val("abort_hold", {23'd0, get_outs(1'b0)}, 32'd0);
    reset = 1'b1;
    run_session(1'b0, 1'b1, 1'b0, 1'b0);
    end_session(1'b0, 1'b1, 2);

    // Minimal parameters on the second instance.
    run_session(1'b1, 1'b1, 1'b0, 1'b0);
    end_session(1'b1, 1'b1, 2);
    run_session(1'b1, 1'b0, 1'b0, 1'b0);
    end_session(1'b1, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
